// File: rtl/mac_row_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mac_row_seq
//  Description : Sequencer for one row of MAC tiles. Streams col kernel
//                words (LOAD) and then num_act activation words (EXEC) to
//                the row's west input, and waits for num_act results to
//                leave the last column (DRAIN) before signalling done.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_row_seq #(
  parameter int bw     = 4,
  parameter int col    = 8,
  parameter int len_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [len_bw-1:0] num_act,
  input  logic [bw-1:0]     data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [bw-1:0]     in_w,
  output logic [1:0]        inst_w,
  input  logic [col-1:0]    row_valid,
  output logic              busy,
  output logic              done,
  output logic [1:0]        phase
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    EXEC  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Kernel-load counter only needs to reach col-1.
  localparam int c_lcw = (col > 1) ? $clog2(col) : 1;
  localparam logic [c_lcw-1:0] c_load_last = c_lcw'(col - 1);

  state_t            r_state;
  logic [len_bw-1:0] r_num_act;
  logic [c_lcw-1:0]  r_load_cnt;
  logic [len_bw-1:0] r_exec_cnt;
  logic [len_bw-1:0] r_out_cnt;
  logic [bw-1:0]     r_in_w;
  logic [1:0]        r_inst_w;
  logic              r_done;

  logic w_ready;
  logic w_accept;
  logic w_last_valid;
  logic w_unused;

  // Only the last column's valid flag marks a finished result.
  assign w_last_valid = row_valid[col-1];
  assign w_unused     = ^row_valid;

  // Input handshake: data is taken only while feeding the row.
  always_comb begin
    w_ready  = (r_state == LOAD) || (r_state == EXEC);
    w_accept = w_ready && data_valid;
  end

  assign data_ready = w_ready;
  assign in_w       = r_in_w;
  assign inst_w     = r_inst_w;
  assign done       = r_done;
  assign busy       = (r_state != IDLE);
  assign phase      = r_state;

  // Job FSM, beat counters, result counter and registered row outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_num_act  <= '0;
      r_load_cnt <= '0;
      r_exec_cnt <= '0;
      r_out_cnt  <= '0;
      r_in_w     <= '0;
      r_inst_w   <= 2'b00;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // A non-accepted cycle sends a bubble into the row.
      r_in_w <= w_accept ? data_in : '0;
      if (!w_accept)
        r_inst_w <= 2'b00;
      else if (r_state == LOAD)
        r_inst_w <= 2'b01;
      else
        r_inst_w <= 2'b10;

      // Results may arrive in any non-idle phase; count saturates at job size.
      if ((r_state != IDLE) && w_last_valid && (r_out_cnt != r_num_act))
        r_out_cnt <= r_out_cnt + len_bw'(1);

      case (r_state)
        IDLE: begin
          if (start) begin
            if (num_act != '0) begin
              r_num_act  <= num_act;
              r_load_cnt <= '0;
              r_exec_cnt <= '0;
              r_out_cnt  <= '0;
              r_state    <= LOAD;
            end else begin
              // Empty job completes immediately without leaving IDLE.
              r_done <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (w_accept) begin
            if (r_load_cnt == c_load_last)
              r_state <= EXEC;
            else
              r_load_cnt <= r_load_cnt + c_lcw'(1);
          end
        end
        EXEC: begin
          if (w_accept) begin
            if (r_exec_cnt == (r_num_act - len_bw'(1)))
              r_state <= DRAIN;
            else
              r_exec_cnt <= r_exec_cnt + len_bw'(1);
          end
        end
        DRAIN: begin
          // Also covers results that all arrived before DRAIN was entered.
          if (r_out_cnt == r_num_act) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_row_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_row_seq
//  Description : Directed self-checking bench for mac_row_seq (col=8).
//                Inputs change and outputs are sampled 1 ns after each
//                rising edge; observation k is taken after edge k of a job.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_row_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] num_act;
  logic [3:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic [3:0] in_w;
  logic [1:0] inst_w;
  logic [7:0] row_valid;
  logic       busy;
  logic       done;
  logic [1:0] phase;

  int n_pass;
  int n_total;

  mac_row_seq #(.bw(4), .col(8), .len_bw(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_act    (num_act),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .in_w       (in_w),
    .inst_w     (inst_w),
    .row_valid  (row_valid),
    .busy       (busy),
    .done       (done),
    .phase      (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; num_act = 8'd0; data_in = 4'h0;
    data_valid = 1'b0; row_valid = 8'h00;
    tick; tick;
    n_total++;
    if ({phase, busy, done, inst_w, in_w, data_ready} !== 11'd0) begin
      $display("FAIL reset_outputs: got phase=%0d busy=%0b done=%0b inst_w=%b in_w=%h ready=%0b, want all 0",
               phase, busy, done, inst_w, in_w, data_ready);
    end else n_pass++;
    #2 reset = 1'b0;
    tick;
    n_total++;
    if (phase !== 2'd0 || busy !== 1'b0) begin
      $display("FAIL reset_release_idle: got phase=%0d busy=%0b, want 0/0", phase, busy);
    end else n_pass++;
  endtask

  // col=8, num_act=3, data_valid held high, three last-column pulses.
  task automatic test_basic_job;
    logic [3:0] prev;
    logic [1:0] exp_inst;
    start = 1'b1; num_act = 8'd3; data_valid = 1'b1; data_in = 4'h1; row_valid = 8'h00;
    for (int k = 1; k <= 18; k++) begin
      prev = data_in;
      tick;
      start = 1'b0;
      exp_inst = (k >= 2 && k <= 9) ? 2'b01 : ((k >= 10 && k <= 12) ? 2'b10 : 2'b00);
      n_total++;
      if (inst_w !== exp_inst) begin
        $display("FAIL basic_inst_w[k=%0d]: got %b, want %b", k, inst_w, exp_inst);
      end else n_pass++;
      n_total++;
      if (in_w !== ((exp_inst != 2'b00) ? prev : 4'h0)) begin
        $display("FAIL basic_in_w[k=%0d]: got %h, want %h", k, in_w,
                 (exp_inst != 2'b00) ? prev : 4'h0);
      end else n_pass++;
      n_total++;
      if (done !== (k == 17)) begin
        $display("FAIL basic_done[k=%0d]: got %0b, want %0b", k, done, (k == 17));
      end else n_pass++;
      data_in = 4'((k * 5) + 1);
      // Bit 7 pulses three times; a pulse on other bits must not count.
      if (k == 11 || k == 13 || k == 15) row_valid = 8'h80;
      else if (k == 12) row_valid = 8'h7F;
      else row_valid = 8'h00;
    end
    n_total++;
    if (busy !== 1'b0) begin
      $display("FAIL basic_end_busy: got %0b, want 0", busy);
    end else n_pass++;
    data_valid = 1'b0;
  endtask

  // Bubbles in LOAD; results arrive early (during LOAD) and saturate.
  task automatic test_bubbles_early_results;
    logic [1:0] exp_inst;
    int         n_load;
    n_load = 0;
    start = 1'b1; num_act = 8'd1; data_valid = 1'b0; data_in = 4'hA; row_valid = 8'h00;
    for (int k = 1; k <= 20; k++) begin
      tick;
      start = 1'b0;
      exp_inst = (k >= 2 && k <= 16 && (k % 2 == 0)) ? 2'b01 : ((k == 17) ? 2'b10 : 2'b00);
      if (inst_w == 2'b01) n_load++;
      n_total++;
      if (inst_w !== exp_inst) begin
        $display("FAIL bubble_inst_w[k=%0d]: got %b, want %b", k, inst_w, exp_inst);
      end else n_pass++;
      n_total++;
      if (data_ready !== (k <= 16)) begin
        $display("FAIL bubble_ready[k=%0d]: got %0b, want %0b", k, data_ready, (k <= 16));
      end else n_pass++;
      n_total++;
      if (done !== (k == 18)) begin
        $display("FAIL bubble_done[k=%0d]: got %0b, want %0b", k, done, (k == 18));
      end else n_pass++;
      data_valid = (k >= 16) ? 1'b1 : ((k % 2) == 1);
      row_valid  = (k == 5 || k == 7) ? 8'h80 : 8'h00;
    end
    n_total++;
    if (n_load !== 8) begin
      $display("FAIL bubble_load_count: got %0d, want 8", n_load);
    end else n_pass++;
    data_valid = 1'b0;
  endtask

  task automatic test_zero_len;
    start = 1'b1; num_act = 8'd0; data_valid = 1'b1; row_valid = 8'h00;
    for (int k = 1; k <= 3; k++) begin
      tick;
      start = 1'b0;
      n_total++;
      if (done !== (k == 1) || busy !== 1'b0 || inst_w !== 2'b00) begin
        $display("FAIL zero_len[k=%0d]: got done=%0b busy=%0b inst_w=%b, want done=%0b busy=0 inst_w=00",
                 k, done, busy, inst_w, (k == 1));
      end else n_pass++;
    end
    data_valid = 1'b0;
  endtask

  // Abort in EXEC after 2 of 5 beats, then a fresh job of length 1.
  task automatic test_reset_mid_job;
    start = 1'b1; num_act = 8'd5; data_valid = 1'b1; data_in = 4'h6; row_valid = 8'h00;
    for (int k = 1; k <= 11; k++) begin
      tick;
      start = 1'b0;
    end
    n_total++;
    if (phase !== 2'd2 || inst_w !== 2'b10) begin
      $display("FAIL abort_pre_exec: got phase=%0d inst_w=%b, want 2/10", phase, inst_w);
    end else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++;
    if ({phase, busy, done, inst_w, in_w, data_ready} !== 11'd0) begin
      $display("FAIL abort_async: got phase=%0d busy=%0b done=%0b inst_w=%b in_w=%h ready=%0b, want all 0",
               phase, busy, done, inst_w, in_w, data_ready);
    end else n_pass++;
    tick; tick;
    reset = 1'b0;
    tick;
    n_total++;
    if (done !== 1'b0 || phase !== 2'd0) begin
      $display("FAIL abort_no_done: got done=%0b phase=%0d, want 0/0", done, phase);
    end else n_pass++;
    start = 1'b1; num_act = 8'd1;
    for (int k = 1; k <= 13; k++) begin
      tick;
      start = 1'b0;
      n_total++;
      if (done !== (k == 12)) begin
        $display("FAIL abort_rerun_done[k=%0d]: got %0b, want %0b", k, done, (k == 12));
      end else n_pass++;
      row_valid = (k == 10) ? 8'h80 : 8'h00;
    end
    data_valid = 1'b0;
  endtask

  // Restart attempt in DRAIN and num_act changed mid-job are both ignored.
  task automatic test_busy_start_ignored;
    start = 1'b1; num_act = 8'd2; data_valid = 1'b1; row_valid = 8'h00;
    for (int k = 1; k <= 17; k++) begin
      tick;
      start   = (k == 11);
      num_act = 8'd7;
      if (k >= 11 && k <= 14) begin
        n_total++;
        if (phase !== 2'd3) begin
          $display("FAIL ignore_phase[k=%0d]: got %0d, want 3", k, phase);
        end else n_pass++;
      end
      n_total++;
      if (done !== (k == 15)) begin
        $display("FAIL ignore_done[k=%0d]: got %0b, want %0b", k, done, (k == 15));
      end else n_pass++;
      if (k >= 16) begin
        n_total++;
        if (busy !== 1'b0) begin
          $display("FAIL ignore_no_queue[k=%0d]: got busy=%0b, want 0", k, busy);
        end else n_pass++;
      end
      row_valid = (k == 11 || k == 13) ? 8'h80 : 8'h00;
    end
    data_valid = 1'b0;
  endtask

  // Last-column pulses while idle must not count toward the next job.
  task automatic test_idle_pulses;
    start = 1'b0; num_act = 8'd2; data_valid = 1'b1; row_valid = 8'h80;
    for (int k = 1; k <= 3; k++) begin
      tick;
      n_total++;
      if (phase !== 2'd0 || done !== 1'b0) begin
        $display("FAIL idle_pulse_state[k=%0d]: got phase=%0d done=%0b, want 0/0", k, phase, done);
      end else n_pass++;
    end
    start = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick;
      start = 1'b0;
      n_total++;
      if (done !== (k == 15)) begin
        $display("FAIL idle_pulse_done[k=%0d]: got %0b, want %0b", k, done, (k == 15));
      end else n_pass++;
      row_valid = (k == 11 || k == 13) ? 8'h80 : 8'h00;
    end
    data_valid = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset;
    test_basic_job;
    test_bubbles_early_results;
    test_zero_len;
    test_reset_mid_job;
    test_busy_start_ignored;
    test_idle_pulses;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
